// File: rtl/mem_responder_pkg.sv
// Shared cache/memory definitions: block width, bus address width, responder states and ops.
package mem_responder_pkg;

  localparam int BLOCK_BITS    = 128;
  localparam int MEM_ADDR_BITS = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Block storage: one synchronous write port, one combinational read port, contents never reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [BLOCK_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [BLOCK_BITS-1:0] rdata
);

  logic [BLOCK_BITS-1:0] lines [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) lines[waddr] <= wdata;
  end

  assign rdata = lines[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency block memory responder: one transaction in flight, sticky protocol-error flag.
//   state   | meaning
//   ST_IDLE | waiting for mem_read/mem_write
//   ST_BUSY | counting down the remaining latency
//   ST_RESP | one-cycle mem_ready; a write commits at the edge ending this state
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [MEM_ADDR_BITS-1:0] mem_addr,
  input  logic [BLOCK_BITS-1:0]    mem_wdata,
  output logic [BLOCK_BITS-1:0]    mem_rdata,
  output logic                     mem_ready,
  output logic                     proto_err
);

  localparam int CNT_W = 4;

  mem_state_t               state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     load;
  mem_op_t                  op_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [BLOCK_BITS-1:0]    wdata_q;
  logic [1:0]               req_q;
  logic                     proto_err_q;
  logic                     violation;
  logic                     arr_we;
  logic [BLOCK_BITS-1:0]    arr_rdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          load      = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        // counter reaches 0 on the edge that enters RESP, giving ready in cycle LATENCY
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Requester must hold op and full address steady until mem_ready; both-high in IDLE is also an error.
  always_comb begin
    violation = 1'b0;
    if (state == ST_IDLE)
      violation = mem_read && mem_write;
    else
      violation = ({mem_read, mem_write} != req_q) || (mem_addr != addr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        op_q    <= mem_write ? OP_WRITE : OP_READ;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        req_q   <= {mem_read, mem_write};
      end
      if (violation) proto_err_q <= 1'b1;
    end
  end

  assign arr_we = (state == ST_RESP) && (op_q == OP_WRITE) && !rst;

  mem_array #(.ADDR_BITS(ADDR_BITS)) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (addr_q[ADDR_BITS-1:0]),
    .wdata (wdata_q),
    .raddr (addr_q[ADDR_BITS-1:0]),
    .rdata (arr_rdata)
  );

  assign mem_ready = (state == ST_RESP);
  assign mem_rdata = (state == ST_RESP && op_q == OP_READ) ? arr_rdata : '0;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed table, randomized traffic vs. a behavioural memory model, corner sequences.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, mem_read, mem_write, mem_ready, proto_err;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  logic         rst1, r1_read, r1_write, r1_ready, r1_err;
  logic [27:0]  r1_addr;
  logic [127:0] r1_wdata, r1_rdata;

  mem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .proto_err(proto_err)
  );

  mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
    .clk(clk), .rst(rst1), .mem_read(r1_read), .mem_write(r1_write),
    .mem_addr(r1_addr), .mem_wdata(r1_wdata), .mem_rdata(r1_rdata),
    .mem_ready(r1_ready), .proto_err(r1_err)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] mdl [256];
  bit           mv  [256];

  localparam logic [127:0] D_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D_B = 128'hB0B0_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] D_C = 128'hC0C0_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [127:0] D_D = 128'hD0D0_0105_0105_0105_0105_0105_0105_0105;
  localparam logic [127:0] D_E = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_00FF;
  localparam logic [127:0] D_F = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
  localparam logic [127:0] D_G = 128'h9999_0009_9999_0009_9999_0009_9999_0009;
  localparam logic [127:0] D_X = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] D_H = 128'h2222_0002_2222_0002_2222_0002_2222_0002;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  task automatic model_apply(input logic wr, input logic [27:0] a, input logic [127:0] d);
    if (wr) begin
      mdl[a[7:0]] = d;
      mv[a[7:0]]  = 1'b1;
    end
  endtask

  // Called at the start of cycle 0; returns at the start of the cycle after mem_ready with inputs still held.
  task automatic txn(input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, input logic [127:0] exp_rd);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge clk);
    chk("ready_cycle0", mem_ready, 1'b0);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      @(negedge clk);
      chk("ready_timing", mem_ready, c == LAT);
      chk("rdata", mem_rdata, (c == LAT && rd && !wr) ? exp_rd : 128'd0);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [27:0] a,
                              input logic [127:0] d, input logic [127:0] e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = e;
    return v;
  endfunction

  initial begin
    logic [127:0] exp;
    rst = 1'b1; rst1 = 1'b1;
    idle();
    r1_read = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("reset_ready", mem_ready, 1'b0);
    chk("reset_rdata", mem_rdata, 128'd0);
    chk("reset_err", proto_err, 1'b0);
    chk("reset_ready_l1", r1_ready, 1'b0);
    tick();
    rst = 1'b0; rst1 = 1'b0;

    // LATENCY=1: two held writes then two held reads, ready every second cycle.
    for (int k = 0; k <= 8; k++) begin
      r1_write = (k < 4);
      r1_read  = (k >= 4 && k < 8);
      r1_addr  = 28'h1;
      r1_wdata = D_A;
      @(negedge clk);
      chk("l1_ready", r1_ready, (k == 1 || k == 3 || k == 5 || k == 7));
      chk("l1_rdata", r1_rdata, (k == 5 || k == 7) ? D_A : 128'd0);
      tick();
    end
    chk("l1_err", r1_err, 1'b0);

    // Directed table, back-to-back with no idle cycle between entries.
    tbl.push_back(mk(0, 1, 28'h0000005, D_A, '0));
    tbl.push_back(mk(1, 0, 28'h0000005, '0, D_A));
    tbl.push_back(mk(0, 1, 28'h0000007, D_C, '0));
    tbl.push_back(mk(0, 1, 28'h0000003, D_B, '0));
    tbl.push_back(mk(1, 0, 28'h0000007, '0, D_C));
    tbl.push_back(mk(1, 0, 28'h0000003, '0, D_B));
    tbl.push_back(mk(0, 1, 28'h0000105, D_D, '0));
    tbl.push_back(mk(1, 0, 28'h0000005, '0, D_D));
    tbl.push_back(mk(1, 0, 28'hFFFFF05, '0, D_D));
    tbl.push_back(mk(0, 1, 28'h00000FF, D_E, '0));
    tbl.push_back(mk(1, 0, 28'h00000FF, '0, D_E));
    tbl.push_back(mk(0, 1, 28'h0000000, D_F, '0));
    tbl.push_back(mk(1, 0, 28'h0000000, '0, D_F));
    foreach (tbl[i]) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
      model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
    end
    idle();
    @(negedge clk);
    chk("table_err", proto_err, 1'b0);
    tick();

    // Randomized traffic against the memory model.
    for (int i = 0; i < 40; i++) begin
      logic         rd;
      logic [27:0]  a;
      logic [127:0] d;
      int           gap;
      rd = 1'($urandom_range(0, 1));
      a  = 28'($urandom);
      if (rd && !mv[a[7:0]]) rd = 1'b0;
      d  = {$urandom, $urandom, $urandom, $urandom};
      exp = rd ? mdl[a[7:0]] : 128'd0;
      txn(rd, !rd, a, d, exp);
      model_apply(!rd, a, d);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        idle();
        repeat (gap) tick();
      end
    end
    idle();
    @(negedge clk);
    chk("random_err", proto_err, 1'b0);
    tick();

    // Reset in cycle 2 aborts a pending write.
    txn(0, 1, 28'h0000009, D_G, '0);
    model_apply(1'b1, 28'h0000009, D_G);
    mem_write = 1'b1; mem_read = 1'b0; mem_addr = 28'h0000009; mem_wdata = D_X;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort_no_ready", mem_ready, 1'b0);
      tick();
    end
    chk("abort_err", proto_err, 1'b0);
    txn(1, 0, 28'h0000009, '0, mdl[9]);
    idle();
    tick();

    // Request dropped mid-flight: still completes, proto_err set.
    exp = mdl[5];
    mem_read = 1'b1; mem_addr = 28'h0000005;
    tick();
    tick();
    idle();
    for (int c = 2; c <= LAT; c++) begin
      @(negedge clk);
      chk("drop_ready", mem_ready, c == LAT);
      chk("drop_rdata", mem_rdata, (c == LAT) ? exp : 128'd0);
      tick();
    end
    @(negedge clk);
    chk("drop_err", proto_err, 1'b1);
    tick();
    do_reset();
    @(negedge clk);
    chk("drop_err_cleared", proto_err, 1'b0);
    tick();

    // Read and write both high: serviced as write, sticky error.
    txn(1, 1, 28'h0000002, D_H, '0);
    model_apply(1'b1, 28'h0000002, D_H);
    idle();
    @(negedge clk);
    chk("both_err", proto_err, 1'b1);
    repeat (5) tick();
    @(negedge clk);
    chk("both_err_sticky", proto_err, 1'b1);
    tick();
    txn(1, 0, 28'h0000002, '0, mdl[2]);
    idle();
    @(negedge clk);
    chk("both_err_still", proto_err, 1'b1);
    tick();
    do_reset();
    @(negedge clk);
    chk("both_err_cleared", proto_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
